// File: rtl/down_counter_timer.sv
// down_counter_timer: loadable down-counter with pause/resume, a one-cycle
// done pulse on reaching zero and optional auto-reload of the last loaded value.
// All outputs are registered; reset is synchronous and active-low.
module down_counter_timer #(
  parameter int WIDTH       = 4,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             pause,
  input  logic             tick,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] q_reg, q_next;
  logic [WIDTH-1:0] rl_reg, rl_next;
  logic             done_reg, done_next;
  logic             busy_reg, busy_next;

  // Next-state, next-count and registered-output decode; load overrides the FSM.
  always_comb begin
    state_next = state_reg;
    q_next     = q_reg;
    rl_next    = rl_reg;
    done_next  = 1'b0;

    if (load) begin
      q_next     = load_val;
      rl_next    = load_val;
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          // Starting from zero would finish immediately; it is simply refused.
          if (start && (q_reg != ZERO)) begin
            state_next = ST_RUN;
          end
        end
        ST_RUN: begin
          if (pause) begin
            state_next = ST_HOLD;
          end else if (tick) begin
            if (q_reg > ONE) begin
              q_next = q_reg - ONE;
            end else begin
              // Covers q==1 and guards against underflow should q ever be 0 here.
              q_next     = ZERO;
              done_next  = 1'b1;
              state_next = ST_DONE;
            end
          end
        end
        ST_HOLD: begin
          if (start) begin
            state_next = ST_RUN;
          end
        end
        ST_DONE: begin
          // A zero reload value would spin through DONE forever, so it never restarts.
          if ((AUTO_RELOAD || start) && (rl_reg != ZERO)) begin
            q_next     = rl_reg;
            state_next = ST_RUN;
          end
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end

    busy_next = (state_next == ST_RUN) || (state_next == ST_HOLD);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      q_reg     <= ZERO;
      rl_reg    <= ZERO;
      done_reg  <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      q_reg     <= q_next;
      rl_reg    <= rl_next;
      done_reg  <= done_next;
      busy_reg  <= busy_next;
    end
  end

  assign q    = q_reg;
  assign busy = busy_reg;
  assign done = done_reg;

endmodule

// File: tb/tb_down_counter_timer.sv
// Bench for down_counter_timer: two instances (reload off / on) share one
// stimulus stream and are compared every cycle against a behavioural model,
// followed by directed sequences and a randomized run.
module tb_down_counter_timer;

  logic       clk = 1'b0;
  logic       rst, load, start, pause, tick;
  logic [3:0] load_val;
  logic [3:0] q_a, q_b;
  logic       busy_a, busy_b, done_a, done_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  down_counter_timer #(.WIDTH(4), .AUTO_RELOAD(1'b0)) dut_a (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .start(start),
    .pause(pause), .tick(tick), .q(q_a), .busy(busy_a), .done(done_a)
  );

  down_counter_timer #(.WIDTH(4), .AUTO_RELOAD(1'b1)) dut_b (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .start(start),
    .pause(pause), .tick(tick), .q(q_b), .busy(busy_b), .done(done_b)
  );

  // Model: "running" covers counting and paused; "finished" means sitting at zero.
  typedef struct packed {
    logic [3:0] q;
    logic [3:0] rl;
    logic       running;
    logic       paused;
    logic       finished;
    logic       done;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t mdl_step(mdl_t m, bit ar, bit r, bit ld, logic [3:0] lv,
                                    bit st, bit pa, bit tk);
    mdl_t n = m;
    n.done = 1'b0;
    if (!r) begin
      n = '0;
    end else if (ld) begin
      n.q = lv;
      n.rl = lv;
      n.running = 1'b0;
      n.paused = 1'b0;
      n.finished = 1'b0;
    end else if (m.paused) begin
      if (st) n.paused = 1'b0;
    end else if (m.running) begin
      if (pa) begin
        n.paused = 1'b1;
      end else if (tk) begin
        n.q = m.q - 4'd1;
        if (n.q == 4'd0) begin
          n.running = 1'b0;
          n.finished = 1'b1;
          n.done = 1'b1;
        end
      end
    end else if (m.finished) begin
      if ((ar || st) && m.rl != 4'd0) begin
        n.q = m.rl;
        n.running = 1'b1;
        n.finished = 1'b0;
      end
    end else if (st && m.q != 4'd0) begin
      n.running = 1'b1;
    end
    return n;
  endfunction

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock transaction: drive, advance the model, compare both instances.
  task automatic cycle(input bit r, input bit ld, input int lv, input bit st,
                       input bit pa, input bit tk);
    @(negedge clk);
    rst = r; load = ld; load_val = lv[3:0]; start = st; pause = pa; tick = tk;
    @(posedge clk);
    ma = mdl_step(ma, 1'b0, r, ld, lv[3:0], st, pa, tk);
    mb = mdl_step(mb, 1'b1, r, ld, lv[3:0], st, pa, tk);
    #1;
    $display("t=%0t rst=%0b ld=%0b lv=%0d st=%0b pa=%0b tk=%0b | a q=%0d b=%0b d=%0b | b q=%0d b=%0b d=%0b",
             $time, r, ld, lv[3:0], st, pa, tk, q_a, busy_a, done_a, q_b, busy_b, done_b);
    check_val("a_q", int'(q_a), int'(ma.q));
    check_val("a_busy", int'(busy_a), int'(ma.running));
    check_val("a_done", int'(done_a), int'(ma.done));
    check_val("b_q", int'(q_b), int'(mb.q));
    check_val("b_busy", int'(busy_b), int'(mb.running));
    check_val("b_done", int'(done_b), int'(mb.done));
  endtask

  initial begin
    int dcnt;
    rst = 1'b0; load = 1'b0; load_val = '0; start = 1'b0; pause = 1'b0; tick = 1'b0;
    ma = '0; mb = '0;

    // Reset beats load.
    cycle(0, 1, 9, 0, 0, 0);
    cycle(0, 1, 9, 0, 0, 0);
    check_val("rst_q", int'(q_a), 0);
    check_val("rst_busy", int'(busy_a), 0);
    check_val("rst_done", int'(done_a), 0);

    // Load 5, count to zero with tick every clock.
    cycle(1, 1, 5, 0, 0, 0);
    check_val("t2_load_q", int'(q_a), 5);
    cycle(1, 0, 0, 1, 0, 1);
    check_val("t2_start_q", int'(q_a), 5);
    check_val("t2_start_busy", int'(busy_a), 1);
    for (int i = 4; i >= 0; i--) begin
      cycle(1, 0, 0, 0, 0, 1);
      check_val("t2_q", int'(q_a), i);
      check_val("t2_done", int'(done_a), (i == 0) ? 1 : 0);
    end
    check_val("t2_busy_done", int'(busy_a), 0);
    cycle(1, 0, 0, 0, 0, 1);
    check_val("t2_stay_q", int'(q_a), 0);
    check_val("t2_pulse_end", int'(done_a), 0);
    check_val("t2_reload_q", int'(q_b), 5);

    // Tick every third clock: nine ticks from 9 reach zero.
    cycle(1, 1, 9, 0, 0, 0);
    cycle(1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 27; i++) cycle(1, 0, 0, 0, 0, (i % 3) == 2);
    check_val("t3_q", int'(q_a), 0);
    check_val("t3_done", int'(done_a), 1);

    // Pause at 4, hold, then resume.
    cycle(1, 1, 7, 0, 0, 0);
    cycle(1, 0, 0, 1, 0, 1);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0, 1, 1);
    check_val("t4_hold_q", int'(q_a), 4);
    check_val("t4_hold_busy", int'(busy_a), 1);
    cycle(1, 0, 0, 1, 0, 1);
    check_val("t4_resume_q", int'(q_a), 4);
    for (int i = 3; i >= 0; i--) begin
      cycle(1, 0, 0, 0, 0, 1);
      check_val("t4_q", int'(q_a), i);
    end

    // Auto-reload of 3: done every fourth clock.
    cycle(1, 1, 3, 0, 0, 0);
    cycle(1, 0, 0, 1, 0, 1);
    dcnt = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(1, 0, 0, 0, 0, 1);
      if (done_b) dcnt++;
      check_val("t5_q", int'(q_b), (i % 4 == 3) ? 3 : (2 - (i % 4) + ((i % 4 == 3) ? 1 : 0)));
    end
    check_val("t5_done_cnt", dcnt, 2);
    cycle(1, 1, 0, 0, 0, 1);
    cycle(1, 0, 0, 1, 0, 1);
    check_val("t5_zero_q", int'(q_b), 0);
    check_val("t5_zero_busy", int'(busy_b), 0);
    check_val("t5_zero_done", int'(done_b), 0);

    // Load mid-run, then reset mid-count.
    cycle(1, 1, 15, 0, 0, 0);
    cycle(1, 0, 0, 1, 0, 1);
    for (int i = 0; i < 9; i++) cycle(1, 0, 0, 0, 0, 1);
    check_val("t6_q6", int'(q_a), 6);
    cycle(1, 1, 15, 1, 0, 1);
    check_val("t6_load_q", int'(q_a), 15);
    check_val("t6_load_busy", int'(busy_a), 0);
    cycle(1, 0, 0, 1, 0, 1);
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0, 0, 1);
    check_val("t6_q10", int'(q_a), 10);
    cycle(0, 0, 0, 0, 0, 1);
    check_val("t6_rst_q", int'(q_a), 0);
    cycle(1, 0, 0, 1, 0, 1);
    check_val("t6_norun_busy", int'(busy_a), 0);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      cycle($urandom_range(0, 49) != 0,
            $urandom_range(0, 11) == 0,
            int'($urandom_range(0, 15)),
            $urandom_range(0, 5) == 0,
            $urandom_range(0, 9) == 0,
            $urandom_range(0, 2) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
